ysyx_25020037_lsu: RTL and testbench
====================================

// Module: ysyx_25020037_lsu
// PURPOSE
//  Load/store stage directly downstream of the execute stage. Accepts one op per exu_valid/lsu_ready handshake.
//  Issues a single data-memory request for loads and stores, then aligns and extends load data.
//  Hands the result plus the writeback pass-through field to the writeback stage via lsu_valid/wbu_ready.
// PARAMETERS
//  PASS_W   64   width of opaque writeback pass-through field (rd, wen, csr info), carried unchanged
//  ADDR_W   32   data address width
//  DATA_W   32   data width; only 32 supported
// PORTS
//  clk          in   1       clock; all state on posedge
//  rst          in   1       synchronous, active-high reset
//  exu_valid    in   1       execute stage presents an op
//  lsu_ready    out  1       LSU can accept an op this cycle
//  ld_en        in   1       op is a load
//  st_en        in   1       op is a store (ld_en & st_en never both set)
//  mem_size     in   2       0=byte 1=half 2=word 3=reserved(err)
//  ld_unsigned  in   1       zero-extend load (lbu/lhu)
//  addr         in   32      ALU result: memory address, or writeback value for non-mem ops
//  st_data      in   32      store data, LSB-aligned
//  pass_in      in   PASS_W  writeback fields from execute
//  lsu_valid    out  1       result valid to writeback
//  wbu_ready    in   1       writeback accepts result
//  wb_data      out  32      load data (extended) or addr for non-mem ops; 0 for stores
//  pass_out     out  PASS_W  registered copy of pass_in
//  lsu_err      out  1       access fault or misalignment on this result
//  mem_req      out  1       memory request, held until mem_gnt
//  mem_we       out  1       1=write
//  mem_addr     out  32      word-aligned address (addr & ~3)
//  mem_wdata    out  32      store data shifted to byte lane
//  mem_wstrb    out  4       byte enables; 0 for reads
//  mem_gnt      in   1       request accepted
//  mem_rvalid   in   1       response (read data or write ack)
//  mem_rdata    in   32      read word
//  mem_err      in   1       response error, qualified by mem_rvalid
// BEHAVIOUR
//  - Reset: state=IDLE; lsu_valid, lsu_err, mem_req, mem_we=0; wb_data, pass_out, mem_addr, mem_wdata, mem_wstrb=0.
//  - lsu_ready = (state==IDLE) & (~lsu_valid | wbu_ready). Accept = exu_valid & lsu_ready; latch addr, st_data, size, flags, pass_in.
//  - FSM IDLE->REQ->WAIT->IDLE.
//  - Non-mem op: stay IDLE; next cycle lsu_valid=1, wb_data=addr. Latency 1, throughput 1/cycle.
//  - Misaligned (half & addr[0]; word & addr[1:0]!=0; size==3): no request; next cycle lsu_valid=1, lsu_err=1, wb_data=0.
//  - Mem op: next cycle REQ with mem_req=1. Request fields are stable until mem_gnt=1.
//  - mem_gnt in REQ -> WAIT, mem_req=0 next cycle. mem_rvalid comes no earlier than cycle after gnt.
//  - mem_rvalid in WAIT -> IDLE; lsu_valid=1 next cycle, lsu_err=mem_err.
//    Load wb_data = lane of mem_rdata selected by addr[1:0], sign/zero-extended; store or err: wb_data=0.
//  - Min load/store latency (gnt in first REQ cycle, rvalid next): accept + 3 cycles.
//  - Store lanes: byte wstrb=1<<a[1:0], wdata={4{b}}; half wstrb=3<<a[1:0], wdata={2{h}}; word wstrb=F.
//  - lsu_valid, wb_data, pass_out, lsu_err hold until wbu_ready; they clear the cycle after handshake unless a new result lands.
//  - mem_rvalid in IDLE/REQ is ignored (stale); mem_gnt outside REQ is ignored.
//  - Reset mid-operation: abort immediately to reset values; a later stale mem_rvalid is ignored.
// STRUCTURE
//  - Shared package/header: FSM state encoding, mem_size codes, lsu_err cause constants.
//  - One sub-module: ysyx_25020037_lsu_align (combinational store lane/strobe gen + load extract/extend).
//  - FSM, input latches and output registers live in the top module.
// TESTING
//  - Non-mem addr=0x1234 -> lsu_valid next cycle, wb_data=0x1234, no mem_req; back-to-back ops 1/cycle.
//  - lb addr=0x8000_0003, rdata=0x80AA_BBCC -> mem_addr=0x8000_0000, wb_data=0xFFFF_FF80; lbu -> 0x0000_0080.
//  - sh addr=0x102, st_data=0x1234_ABCD -> mem_wstrb=4'b1100, mem_wdata=0xABCD_ABCD, wb_data=0.
//  - mem_gnt withheld 3 cycles -> mem_req and fields stable; lsu_ready=0 throughout; result after rvalid.
//  - lw addr=0x101 -> no mem_req, lsu_err=1; load with mem_err=1 -> lsu_err=1, wb_data=0.
//  - wbu_ready=0 for 2 cycles -> outputs held, lsu_ready=0; rst in WAIT then stale rvalid -> no lsu_valid.

Source files
------------

// File: rtl/ysyx_25020037_lsu_pkg.sv
// Shared definitions for the load/store stage:
// FSM states, access size codes and fault causes.
package ysyx_25020037_lsu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } lsu_state_e;

    localparam logic [1:0] SZ_B   = 2'd0;
    localparam logic [1:0] SZ_H   = 2'd1;
    localparam logic [1:0] SZ_W   = 2'd2;
    localparam logic [1:0] SZ_RSV = 2'd3;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_ACCESS   = 2'd2;

    // Reserved size is treated as a misaligned access.
    function automatic logic misaligned(
        input logic [1:0] size,
        input logic [1:0] off
    );
        logic m;
        m = 1'b0;
        case (size)
            SZ_B:    m = 1'b0;
            SZ_H:    m = off[0];
            SZ_W:    m = |off;
            default: m = 1'b1;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ysyx_25020037_lsu_align.sv
// Store byte-lane/strobe generation and load
// lane extraction with sign/zero extension.
module ysyx_25020037_lsu_align
    import ysyx_25020037_lsu_pkg::*;
(
    input  logic [1:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic [31:0] st_data,
    output logic [31:0] st_wdata,
    output logic [3:0]  st_wstrb,
    input  logic [1:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic        ld_unsigned,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [31:0] rsh;

    always_comb begin
        st_wdata = '0;
        st_wstrb = '0;
        case (st_size)
            SZ_B: begin
                st_wdata = {4{st_data[7:0]}};
                st_wstrb = 4'b0001 << st_off;
            end
            SZ_H: begin
                st_wdata = {2{st_data[15:0]}};
                st_wstrb = 4'b0011 << st_off;
            end
            SZ_W: begin
                st_wdata = st_data;
                st_wstrb = 4'b1111;
            end
            default: begin
                st_wdata = '0;
                st_wstrb = '0;
            end
        endcase
    end

    assign rsh = rdata >> {ld_off, 3'b000};

    always_comb begin
        ld_data = '0;
        case (ld_size)
            SZ_B: ld_data = ld_unsigned ? {24'b0, rsh[7:0]}
                                        : {{24{rsh[7]}}, rsh[7:0]};
            SZ_H: ld_data = ld_unsigned ? {16'b0, rsh[15:0]}
                                        : {{16{rsh[15]}}, rsh[15:0]};
            SZ_W: ld_data = rdata;
            default: ld_data = '0;
        endcase
    end

endmodule

// File: rtl/ysyx_25020037_lsu.sv
// Load/store stage: one memory request per op,
// result handed to writeback over a valid/ready pair.
module ysyx_25020037_lsu
    import ysyx_25020037_lsu_pkg::*;
#(
    parameter int PASS_W = 64,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              exu_valid,
    output logic              lsu_ready,
    input  logic              ld_en,
    input  logic              st_en,
    input  logic [1:0]        mem_size,
    input  logic              ld_unsigned,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] st_data,
    input  logic [PASS_W-1:0] pass_in,
    output logic              lsu_valid,
    input  logic              wbu_ready,
    output logic [DATA_W-1:0] wb_data,
    output logic [PASS_W-1:0] pass_out,
    output logic              lsu_err,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [3:0]        mem_wstrb,
    input  logic              mem_gnt,
    input  logic              mem_rvalid,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_err
);

    lsu_state_e state, state_nxt;

    logic              accept;
    logic              is_mem;
    logic              mis;
    logic              issue;
    logic              resp;
    logic [1:0]        cause;
    logic [1:0]        size_q;
    logic [1:0]        off_q;
    logic              ld_q;
    logic              uns_q;
    logic [PASS_W-1:0] pass_q;
    logic [31:0]       st_wdata;
    logic [3:0]        st_wstrb;
    logic [31:0]       ld_data;

    ysyx_25020037_lsu_align u_align (
        .st_size    (mem_size),
        .st_off     (addr[1:0]),
        .st_data    (st_data),
        .st_wdata   (st_wdata),
        .st_wstrb   (st_wstrb),
        .ld_size    (size_q),
        .ld_off     (off_q),
        .ld_unsigned(uns_q),
        .rdata      (mem_rdata),
        .ld_data    (ld_data)
    );

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (issue)      state_nxt = ST_REQ;
            ST_REQ:  if (mem_gnt)    state_nxt = ST_WAIT;
            ST_WAIT: if (mem_rvalid) state_nxt = ST_IDLE;
            default:                 state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        lsu_ready = (state == ST_IDLE) && (!lsu_valid || wbu_ready);
        accept    = exu_valid && lsu_ready;
        is_mem    = ld_en || st_en;
        mis       = is_mem && misaligned(mem_size, addr[1:0]);
        issue     = accept && is_mem && !mis;
        resp      = (state == ST_WAIT) && mem_rvalid;
        cause     = ERR_NONE;
        if (accept && mis)      cause = ERR_MISALIGN;
        else if (resp && mem_err) cause = ERR_ACCESS;
    end

    // Request side: fields are frozen from issue until grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_wstrb <= '0;
        end else if (issue) begin
            mem_req   <= 1'b1;
            mem_we    <= st_en;
            mem_addr  <= {addr[ADDR_W-1:2], 2'b00};
            mem_wdata <= st_en ? st_wdata : '0;
            mem_wstrb <= st_en ? st_wstrb : 4'b0000;
        end else if (state == ST_REQ && mem_gnt) begin
            mem_req   <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            size_q <= '0;
            off_q  <= '0;
            ld_q   <= 1'b0;
            uns_q  <= 1'b0;
            pass_q <= '0;
        end else if (accept) begin
            size_q <= mem_size;
            off_q  <= addr[1:0];
            ld_q   <= ld_en;
            uns_q  <= ld_unsigned;
            pass_q <= pass_in;
        end
    end

    // Result side: a new result wins over clearing after handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_valid <= 1'b0;
            lsu_err   <= 1'b0;
            wb_data   <= '0;
            pass_out  <= '0;
        end else if (accept && !issue) begin
            lsu_valid <= 1'b1;
            lsu_err   <= (cause != ERR_NONE);
            wb_data   <= is_mem ? '0 : addr;
            pass_out  <= pass_in;
        end else if (resp) begin
            lsu_valid <= 1'b1;
            lsu_err   <= (cause != ERR_NONE);
            wb_data   <= (ld_q && !mem_err) ? ld_data : '0;
            pass_out  <= pass_q;
        end else if (lsu_valid && wbu_ready) begin
            lsu_valid <= 1'b0;
            lsu_err   <= 1'b0;
            wb_data   <= '0;
            pass_out  <= '0;
        end
    end

endmodule

// File: tb/tb_ysyx_25020037_lsu.sv
// Directed bench for the load/store stage.
// Inputs driven and outputs sampled on the falling edge.
module tb_ysyx_25020037_lsu;

    logic        clk;
    logic        rst;
    logic        exu_valid;
    logic        lsu_ready;
    logic        ld_en;
    logic        st_en;
    logic [1:0]  mem_size;
    logic        ld_unsigned;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic [63:0] pass_in;
    logic        lsu_valid;
    logic        wbu_ready;
    logic [31:0] wb_data;
    logic [63:0] pass_out;
    logic        lsu_err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        mem_err;

    int errs;
    int checks;

    ysyx_25020037_lsu dut (
        .clk        (clk),
        .rst        (rst),
        .exu_valid  (exu_valid),
        .lsu_ready  (lsu_ready),
        .ld_en      (ld_en),
        .st_en      (st_en),
        .mem_size   (mem_size),
        .ld_unsigned(ld_unsigned),
        .addr       (addr),
        .st_data    (st_data),
        .pass_in    (pass_in),
        .lsu_valid  (lsu_valid),
        .wbu_ready  (wbu_ready),
        .wb_data    (wb_data),
        .pass_out   (pass_out),
        .lsu_err    (lsu_err),
        .mem_req    (mem_req),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_gnt    (mem_gnt),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .mem_err    (mem_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic nclk();
        @(negedge clk);
    endtask

    task automatic drive(input logic ld, input logic st,
                         input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] sd);
        exu_valid   = 1'b1;
        ld_en       = ld;
        st_en       = st;
        mem_size    = sz;
        ld_unsigned = uns;
        addr        = a;
        st_data     = sd;
        pass_in     = {a, ~a};
    endtask

    task automatic idle_in();
        exu_valid = 1'b0;
        ld_en     = 1'b0;
        st_en     = 1'b0;
    endtask

    task automatic mem_op(
        input string tag, input logic ld, input logic st,
        input logic [1:0] sz, input logic uns,
        input logic [31:0] a, input logic [31:0] sd,
        input int gdly, input logic [31:0] rd, input logic err,
        input logic [31:0] e_addr, input logic [31:0] e_wdata,
        input logic [3:0] e_strb, input logic [31:0] e_wb
    );
        drive(ld, st, sz, uns, a, sd);
        wbu_ready = 1'b1;
        nclk();
        idle_in();
        for (int i = 0; i < gdly; i++) begin
            chk({tag, ".req_hold"}, 64'(mem_req), 64'd1);
            chk({tag, ".addr_hold"}, 64'(mem_addr), 64'(e_addr));
            chk({tag, ".wdata_hold"}, 64'(mem_wdata), 64'(e_wdata));
            chk({tag, ".rdy_low"}, 64'(lsu_ready), 64'd0);
            nclk();
        end
        chk({tag, ".req"}, 64'(mem_req), 64'd1);
        chk({tag, ".we"}, 64'(mem_we), 64'(st));
        chk({tag, ".addr"}, 64'(mem_addr), 64'(e_addr));
        chk({tag, ".wdata"}, 64'(mem_wdata), 64'(e_wdata));
        chk({tag, ".wstrb"}, 64'(mem_wstrb), 64'(e_strb));
        mem_gnt = 1'b1;
        nclk();
        mem_gnt = 1'b0;
        chk({tag, ".req_drop"}, 64'(mem_req), 64'd0);
        chk({tag, ".no_early"}, 64'(lsu_valid), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = rd;
        mem_err    = err;
        nclk();
        mem_rvalid = 1'b0;
        mem_err    = 1'b0;
        chk({tag, ".valid"}, 64'(lsu_valid), 64'd1);
        chk({tag, ".wb"}, 64'(wb_data), 64'(e_wb));
        chk({tag, ".err"}, 64'(lsu_err), 64'(err));
        chk({tag, ".pass"}, pass_out, {a, ~a});
        nclk();
        chk({tag, ".clear"}, 64'(lsu_valid), 64'd0);
    endtask

    initial begin
        errs        = 0;
        checks      = 0;
        rst         = 1'b1;
        exu_valid   = 1'b0;
        ld_en       = 1'b0;
        st_en       = 1'b0;
        mem_size    = 2'd0;
        ld_unsigned = 1'b0;
        addr        = '0;
        st_data     = '0;
        pass_in     = '0;
        wbu_ready   = 1'b1;
        mem_gnt     = 1'b0;
        mem_rvalid  = 1'b0;
        mem_rdata   = '0;
        mem_err     = 1'b0;
        nclk();
        nclk();
        chk("rst.valid", 64'(lsu_valid), 64'd0);
        chk("rst.req", 64'(mem_req), 64'd0);
        chk("rst.wb", 64'(wb_data), 64'd0);
        chk("rst.pass", pass_out, 64'd0);
        chk("rst.strb", 64'(mem_wstrb), 64'd0);
        chk("rst.err", 64'(lsu_err), 64'd0);
        rst = 1'b0;
        nclk();
        chk("rdy.idle", 64'(lsu_ready), 64'd1);

        // Non-memory ops, back to back
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h1234, 32'h0);
        nclk();
        chk("nm1.valid", 64'(lsu_valid), 64'd1);
        chk("nm1.wb", 64'(wb_data), 64'h1234);
        chk("nm1.pass", pass_out, {32'h1234, ~32'h1234});
        chk("nm1.req", 64'(mem_req), 64'd0);
        chk("nm1.rdy", 64'(lsu_ready), 64'd1);
        drive(1'b0, 1'b0, 2'd2, 1'b0, 32'h5678, 32'h0);
        nclk();
        idle_in();
        chk("nm2.valid", 64'(lsu_valid), 64'd1);
        chk("nm2.wb", 64'(wb_data), 64'h5678);
        nclk();
        chk("nm.clear", 64'(lsu_valid), 64'd0);
        chk("nm.clear_wb", 64'(wb_data), 64'd0);

        mem_op("lb", 1, 0, 2'd0, 0, 32'h8000_0003, 32'h0, 0,
               32'h80AA_BBCC, 0, 32'h8000_0000, 32'h0, 4'h0,
               32'hFFFF_FF80);
        mem_op("lbu", 1, 0, 2'd0, 1, 32'h8000_0003, 32'h0, 0,
               32'h80AA_BBCC, 0, 32'h8000_0000, 32'h0, 4'h0,
               32'h0000_0080);
        mem_op("lh", 1, 0, 2'd1, 0, 32'h0000_0012, 32'h0, 0,
               32'h8001_0000, 0, 32'h0000_0010, 32'h0, 4'h0,
               32'hFFFF_8001);
        mem_op("sh", 0, 1, 2'd1, 0, 32'h0000_0102, 32'h1234_ABCD, 0,
               32'hFFFF_FFFF, 0, 32'h0000_0100, 32'hABCD_ABCD, 4'hC,
               32'h0);
        mem_op("sb", 0, 1, 2'd0, 0, 32'h0000_0201, 32'h0000_00AB, 0,
               32'h0, 0, 32'h0000_0200, 32'hABAB_ABAB, 4'h2,
               32'h0);
        mem_op("lw_gnt3", 1, 0, 2'd2, 0, 32'h0000_2000, 32'h0, 3,
               32'hDEAD_BEEF, 0, 32'h0000_2000, 32'h0, 4'h0,
               32'hDEAD_BEEF);
        mem_op("lh_err", 1, 0, 2'd1, 0, 32'h0000_0002, 32'h0, 0,
               32'h1234_5678, 1, 32'h0000_0000, 32'h0, 4'h0,
               32'h0);

        // Misaligned word and reserved size
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'h0);
        nclk();
        drive(1'b0, 1'b1, 2'd3, 1'b0, 32'h0000_0300, 32'h0);
        chk("mis.req", 64'(mem_req), 64'd0);
        chk("mis.valid", 64'(lsu_valid), 64'd1);
        chk("mis.err", 64'(lsu_err), 64'd1);
        chk("mis.wb", 64'(wb_data), 64'd0);
        nclk();
        idle_in();
        chk("rsv.req", 64'(mem_req), 64'd0);
        chk("rsv.err", 64'(lsu_err), 64'd1);
        nclk();
        chk("mis.clear_err", 64'(lsu_err), 64'd0);

        // Writeback backpressure
        wbu_ready = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 1'b0, 32'h0000_0077, 32'h0);
        nclk();
        idle_in();
        chk("bp.valid", 64'(lsu_valid), 64'd1);
        chk("bp.rdy0", 64'(lsu_ready), 64'd0);
        nclk();
        chk("bp.hold_v", 64'(lsu_valid), 64'd1);
        chk("bp.hold_wb", 64'(wb_data), 64'h77);
        chk("bp.rdy1", 64'(lsu_ready), 64'd0);
        wbu_ready = 1'b1;
        #1;
        chk("bp.rdy_rel", 64'(lsu_ready), 64'd1);
        nclk();
        chk("bp.clear", 64'(lsu_valid), 64'd0);

        // Reset while waiting for a response
        drive(1'b1, 1'b0, 2'd2, 1'b0, 32'h0000_0040, 32'h0);
        nclk();
        idle_in();
        mem_gnt = 1'b1;
        nclk();
        mem_gnt = 1'b0;
        rst     = 1'b1;
        nclk();
        rst = 1'b0;
        chk("rstw.req", 64'(mem_req), 64'd0);
        chk("rstw.addr", 64'(mem_addr), 64'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h1111_2222;
        nclk();
        mem_rvalid = 1'b0;
        chk("rstw.stale", 64'(lsu_valid), 64'd0);
        chk("rstw.rdy", 64'(lsu_ready), 64'd1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
